// File: rtl/service_dispatcher.sv
// Lobby service dispatcher: buffers issued tickets and hands them out
// round-robin to counters A-E, driving a timed call announcement.
module service_dispatcher #(
   parameter int DEPTH       = 8,
   parameter int CALL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ticket_valid,
   input  logic [5:0] ticket_number,
   input  logic [4:0] next_req,
   output logic       call_valid,
   output logic [2:0] counter_call,
   output logic [5:0] number_service,
   output logic [5:0] A_serviceNumber,
   output logic [5:0] B_serviceNumber,
   output logic [5:0] C_serviceNumber,
   output logic [5:0] D_serviceNumber,
   output logic [5:0] E_serviceNumber,
   output logic [4:0] waiting,
   output logic       queue_full,
   output logic       drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW = (CALL_CYCLES > 1) ? $clog2(CALL_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(CALL_CYCLES - 1);
   localparam logic [4:0]    FULL_CNT  = 5'(DEPTH);

   typedef enum logic {IDLE, CALL} state_t;

   state_t        state, state_nx;
   logic [HW-1:0] hold, hold_nx;
   logic [5:0]    mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [4:0]    pending;
   logic [2:0]    ptr;
   logic [2:0]    cur_ctr;
   logic [5:0]    cur_num;
   logic [5:0]    svc [5];
   logic [3:0]    idx;
   logic          found;
   logic [2:0]    gidx;
   logic [4:0]    gmask;
   logic          grant;
   logic          push, pop;
   logic          full, empty, ticket_ok;

   assign full       = (waiting == FULL_CNT);
   assign empty      = (waiting == 5'd0);
   assign queue_full = full;
   assign ticket_ok  = ticket_valid && (ticket_number != 6'd0);

   // First pending counter at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      gidx  = 3'd0;
      idx   = 4'd0;
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!found && pending[idx[2:0]]) begin
            found = 1'b1;
            gidx  = idx[2:0];
         end
      end
   end

   always_comb begin
      state_nx = state;
      hold_nx  = hold;
      grant    = 1'b0;
      unique case (state)
         IDLE: begin
            if (found && !empty) begin
               grant    = 1'b1;
               state_nx = CALL;
               hold_nx  = HOLD_INIT;
            end
         end
         CALL: begin
            if (hold == '0) state_nx = IDLE;
            else hold_nx = hold - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign pop   = grant;
   assign push  = ticket_ok && (!full || pop);
   assign gmask = grant ? (5'd1 << gidx) : 5'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         state <= state_nx;
         hold  <= hold_nx;
      end
   end

   // Storage needs no reset; head/tail/waiting define validity.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= ticket_number;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         waiting <= 5'd0;
         drop    <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      waiting <= waiting + 5'd1;
         else if (pop && !push) waiting <= waiting - 5'd1;
         drop <= ticket_ok && full && !pop;
      end
   end

   // The grant clear wins over a same-edge request from that counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 5'd0;
         ptr     <= 3'd0;
         cur_ctr <= 3'd0;
         cur_num <= 6'd0;
         for (int i = 0; i < 5; i++) svc[i] <= 6'd0;
      end else begin
         pending <= (pending | next_req) & ~gmask;
         if (grant) begin
            ptr     <= (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
            cur_ctr <= gidx + 3'd1;
            cur_num <= mem[head];
         end
         for (int i = 0; i < 5; i++) begin
            if (gmask[i])         svc[i] <= mem[head];
            else if (next_req[i]) svc[i] <= 6'd0;
         end
      end
   end

   assign call_valid     = (state == CALL);
   assign counter_call   = call_valid ? cur_ctr : 3'd0;
   assign number_service = call_valid ? cur_num : 6'd0;

   assign A_serviceNumber = svc[0];
   assign B_serviceNumber = svc[1];
   assign C_serviceNumber = svc[2];
   assign D_serviceNumber = svc[3];
   assign E_serviceNumber = svc[4];

endmodule

// File: tb/tb_service_dispatcher.sv
// Bench for service_dispatcher: vector table, directed corner cases and
// random traffic checked against a queue-based lobby model.
module tb_service_dispatcher;

   localparam int DEPTH       = 8;
   localparam int CALL_CYCLES = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ticket_valid = 1'b0;
   logic [5:0] ticket_number = 6'd0;
   logic [4:0] next_req = 5'd0;
   logic       call_valid;
   logic [2:0] counter_call;
   logic [5:0] number_service;
   logic [5:0] A_serviceNumber, B_serviceNumber, C_serviceNumber;
   logic [5:0] D_serviceNumber, E_serviceNumber;
   logic [4:0] waiting;
   logic       queue_full;
   logic       drop;
   logic [5:0] dsn [5];

   int checks = 0;
   int errors = 0;

   service_dispatcher #(.DEPTH(DEPTH), .CALL_CYCLES(CALL_CYCLES)) dut (
      .clk(clk), .rst(rst),
      .ticket_valid(ticket_valid), .ticket_number(ticket_number),
      .next_req(next_req),
      .call_valid(call_valid), .counter_call(counter_call),
      .number_service(number_service),
      .A_serviceNumber(A_serviceNumber), .B_serviceNumber(B_serviceNumber),
      .C_serviceNumber(C_serviceNumber), .D_serviceNumber(D_serviceNumber),
      .E_serviceNumber(E_serviceNumber),
      .waiting(waiting), .queue_full(queue_full), .drop(drop)
   );

   assign dsn[0] = A_serviceNumber;
   assign dsn[1] = B_serviceNumber;
   assign dsn[2] = C_serviceNumber;
   assign dsn[3] = D_serviceNumber;
   assign dsn[4] = E_serviceNumber;

   always #5 clk = ~clk;

   // Lobby model: waiting line, outstanding requests, announcement timer.
   int         q[$];
   logic [4:0] m_pend;
   int         m_ptr, m_rem, m_cc, m_ns, m_drop;
   int         m_sn [5];

   function automatic void m_reset();
      q.delete();
      m_pend = 5'd0;
      m_ptr = 0; m_rem = 0; m_cc = 0; m_ns = 0; m_drop = 0;
      for (int i = 0; i < 5; i++) m_sn[i] = 0;
   endfunction

   function automatic void m_step(logic tv, logic [5:0] num, logic [4:0] req);
      int  osz;
      int  g;
      int  h;
      bit  pop;
      osz = q.size();
      g = -1;
      m_drop = 0;
      pop = (m_rem == 0) && (osz > 0) && (m_pend != 5'd0);
      if (!pop && m_rem > 0) m_rem--;
      if (pop) begin
         for (int k = 0; k < 5; k++)
            if (g < 0 && m_pend[(m_ptr + k) % 5]) g = (m_ptr + k) % 5;
         h = q.pop_front();
         m_sn[g] = h;
         m_cc = g + 1;
         m_ns = h;
         m_rem = CALL_CYCLES;
         m_ptr = (g + 1) % 5;
         m_pend[g] = 1'b0;
      end
      for (int i = 0; i < 5; i++)
         if (req[i] && i != g) begin
            m_pend[i] = 1'b1;
            m_sn[i] = 0;
         end
      if (tv && num != 6'd0) begin
         if (osz < DEPTH || pop) q.push_back(int'(num));
         else m_drop = 1;
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit on;
      on = (m_rem > 0);
      chk("call_valid", int'(call_valid), int'(on));
      chk("counter_call", int'(counter_call), on ? m_cc : 0);
      chk("number_service", int'(number_service), on ? m_ns : 0);
      chk("waiting", int'(waiting), q.size());
      chk("queue_full", int'(queue_full), int'(q.size() == DEPTH));
      chk("drop", int'(drop), m_drop);
      for (int i = 0; i < 5; i++)
         chk($sformatf("service_%0d", i), int'(dsn[i]), m_sn[i]);
   endtask

   // Drive after a falling edge, step model on the rising edge, check after.
   task automatic cycle(input logic tv, input logic [5:0] num,
                        input logic [4:0] req);
      ticket_valid = tv;
      ticket_number = num;
      next_req = req;
      @(posedge clk);
      m_step(tv, num, req);
      @(negedge clk);
      ticket_valid = 1'b0;
      ticket_number = 6'd0;
      next_req = 5'd0;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare_all();
   endtask

   typedef struct {
      logic       tv;
      logic [5:0] num;
      logic [4:0] req;
      int         cv, cc, ns, wt, dr;
   } vec_t;

   function automatic vec_t mk(logic tv, int num, int req,
                               int cv, int cc, int ns, int wt, int dr);
      vec_t v;
      v.tv = tv; v.num = 6'(num); v.req = 5'(req);
      v.cv = cv; v.cc = cc; v.ns = ns; v.wt = wt; v.dr = dr;
      return v;
   endfunction

   vec_t tbl [18];

   int gcc[$];
   int gns[$];
   int got[$];
   bit pcv;
   int issued;
   int cyc;

   initial begin
      tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0);
      tbl[1]  = mk(1, 2, 0, 0, 0, 0, 2, 0);
      tbl[2]  = mk(0, 0, 1, 0, 0, 0, 2, 0);
      tbl[3]  = mk(0, 0, 0, 1, 1, 1, 1, 0);
      tbl[4]  = mk(0, 0, 0, 1, 1, 1, 1, 0);
      tbl[5]  = mk(0, 0, 0, 1, 1, 1, 1, 0);
      tbl[6]  = mk(0, 0, 0, 1, 1, 1, 1, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
      tbl[8]  = mk(0, 0, 1, 0, 0, 0, 1, 0);
      tbl[9]  = mk(0, 0, 0, 1, 1, 2, 0, 0);
      tbl[10] = mk(0, 0, 0, 1, 1, 2, 0, 0);
      tbl[11] = mk(0, 0, 0, 1, 1, 2, 0, 0);
      tbl[12] = mk(0, 0, 0, 1, 1, 2, 0, 0);
      tbl[13] = mk(0, 0, 2, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 7, 0, 0, 0, 0, 1, 0);
      tbl[16] = mk(0, 0, 0, 1, 2, 7, 0, 0);
      tbl[17] = mk(1, 0, 0, 1, 2, 7, 0, 0);

      m_reset();
      do_reset();

      // Single flow, empty-queue request, zero ticket ignored.
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].tv, tbl[i].num, tbl[i].req);
         chk($sformatf("tbl%0d_cv", i), int'(call_valid), tbl[i].cv);
         chk($sformatf("tbl%0d_cc", i), int'(counter_call), tbl[i].cc);
         chk($sformatf("tbl%0d_ns", i), int'(number_service), tbl[i].ns);
         chk($sformatf("tbl%0d_wt", i), int'(waiting), tbl[i].wt);
         chk($sformatf("tbl%0d_dr", i), int'(drop), tbl[i].dr);
      end
      chk("tbl_B_number", int'(B_serviceNumber), 7);

      // Asynchronous reset in the middle of a call.
      #2 rst = 1'b1;
      #1;
      chk("rst_call_valid", int'(call_valid), 0);
      chk("rst_counter_call", int'(counter_call), 0);
      chk("rst_number", int'(number_service), 0);
      chk("rst_B_number", int'(B_serviceNumber), 0);
      chk("rst_waiting", int'(waiting), 0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 6'd0, 5'd0);

      // Round robin A, C, E then back to A.
      cycle(1'b1, 6'd1, 5'd0);
      cycle(1'b1, 6'd2, 5'd0);
      cycle(1'b1, 6'd3, 5'b10101);
      pcv = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 6'd0, 5'd0);
         if (call_valid && !pcv) begin
            gcc.push_back(int'(counter_call));
            gns.push_back(int'(number_service));
         end
         pcv = call_valid;
      end
      chk("rr_grants", gcc.size(), 3);
      if (gcc.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("rr_counter%0d", i), gcc[i], 2 * i + 1);
            chk($sformatf("rr_number%0d", i), gns[i], i + 1);
         end
      end
      cycle(1'b1, 6'd4, 5'b00011);
      begin
         int ccw;
         ccw = 0;
         for (int i = 0; i < 10 && ccw == 0; i++) begin
            cycle(1'b0, 6'd0, 5'd0);
            if (call_valid) ccw = int'(counter_call);
         end
         chk("rr_wrap_to_A", ccw, 1);
      end

      // Full queue: drop on ticket 9, then pop and push on the grant edge.
      do_reset();
      for (int i = 1; i <= 9; i++) cycle(1'b1, 6'(i), 5'd0);
      chk("full_drop", int'(drop), 1);
      chk("full_waiting", int'(waiting), 8);
      chk("full_flag", int'(queue_full), 1);
      cycle(1'b0, 6'd0, 5'b01000);
      chk("full_drop_clears", int'(drop), 0);
      cycle(1'b1, 6'd10, 5'd0);
      chk("swap_waiting", int'(waiting), 8);
      chk("swap_drop", int'(drop), 0);
      chk("swap_counter", int'(counter_call), 4);
      chk("swap_D_number", int'(D_serviceNumber), 1);

      // Twenty tickets through the FIFO must come out in issue order.
      do_reset();
      issued = 0;
      pcv = 1'b0;
      cyc = 0;
      while (got.size() < 20 && cyc < 2000) begin
         if (issued < 20 && cyc % 6 == 0) begin
            issued++;
            cycle(1'b1, 6'(issued), 5'($urandom_range(0, 31)));
         end else begin
            cycle(1'b0, 6'd0, (cyc % 3 == 0) ? 5'($urandom_range(0, 31)) : 5'd0);
         end
         if (call_valid && !pcv) got.push_back(int'(number_service));
         pcv = call_valid;
         cyc++;
      end
      chk("order_count", got.size(), 20);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("order%0d", i), got[i], i + 1);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         logic       tv;
         logic [5:0] num;
         logic [4:0] req;
         tv  = ($urandom_range(0, 2) == 0);
         num = 6'($urandom_range(0, 63));
         req = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
         cycle(tv, num, req);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/service_dispatcher.md
# service_dispatcher

Counter-side consumer of the queue-ticket system: takes ticket numbers issued by the ticket front end, holds them in a FIFO, and assigns them one at a time to service counters A–E as those counters request their next customer. Each assignment drives a timed call announcement (counter and number) for the lobby display. It sits between the ticket issuer and the per-counter display logic inside the response system top level.

## Interface
- DEPTH, 8, waiting-ticket FIFO depth (power of two, 2–16)
- CALL_CYCLES, 4, cycles call_valid stays high per announcement (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ticket_valid  in  1  one-cycle pulse: new ticket issued
- ticket_number  in  6  issued number, 1–63 (0 reserved = none)
- next_req  in  5  per-counter "call next" pulse, bit0=A … bit4=E
- call_valid  out  1  announcement active
- counter_call  out  3  called counter, 1=A … 5=E, 0=none
- number_service  out  6  number being announced, 0=none
- A_serviceNumber … E_serviceNumber  out  6 each  number currently served at that counter, 0=idle
- waiting  out  5  tickets held in FIFO (0–DEPTH)
- queue_full  out  1  waiting == DEPTH
- drop  out  1  one-cycle pulse: ticket discarded because FIFO full

## Operation
- Reset (async, any time, including mid-call): FIFO emptied, pending bits cleared, round-robin pointer = A, FSM = IDLE; all outputs 0.
- Enqueue: ticket_valid sampled high and (not full, or a pop occurs on the same edge) → ticket_number written at tail. ticket_number 0 with ticket_valid is ignored (no write, no drop).
- Drop: ticket_valid high, FIFO full, no pop on that edge → ticket discarded, drop=1 for one cycle.
- next_req bit i sampled high → pending[i] set, counter i serviceNumber cleared to 0 on the same edge. Re-request while already pending: no effect.
- FSM IDLE: if pending≠0 and waiting≠0 → grant first pending counter at or after pointer (cyclic A→E), pop FIFO head, load that counter's serviceNumber, number_service and counter_call, clear its pending bit, pointer = granted+1 mod 5, go CALL with hold counter = CALL_CYCLES-1. Otherwise stay IDLE, outputs call_valid=0, counter_call=0, number_service=0.
- FSM CALL: call_valid=1, counter_call/number_service held; hold counter decrements each edge; at 0 → IDLE. No dispatch while in CALL; requests and tickets keep accumulating.
- next_req from the counter being granted on the grant edge is ignored (grant clears dominates).
- Simultaneous enqueue and pop: waiting unchanged; when FIFO was empty no pop can occur (pop uses registered state only).
- Widths: FIFO pointers log2(DEPTH) bits, wrap modulo DEPTH; waiting is a separate 5-bit count.

## Timing
- next_req sampled at edge t → pending at t; earliest dispatch at edge t+1 (call_valid rises after t+1).
- ticket_valid sampled at edge t → waiting increments after t; earliest dispatch of that ticket at edge t+1.
- call_valid high for exactly CALL_CYCLES cycles; back-to-back calls separated by ≥1 IDLE cycle, so dispatch rate ≤ 1 per CALL_CYCLES+1 cycles.
- waiting, queue_full, drop and serviceNumbers are registered; update on the same edge as the causing event.

## Test plan
- Reset then idle: rst pulse mid-CALL → all outputs 0 immediately (before next edge), waiting=0, FSM IDLE.
- Single flow: tickets 1,2 issued; next_req=A → one cycle later call_valid=1, counter_call=1, number_service=1, A_serviceNumber=1, waiting=1, for 4 cycles; then 0.
- Round-robin: 3 tickets queued, next_req=5'b10101 same cycle → grants A(1), C(2), E(3) in order, each 4-cycle call with 1 idle cycle between; pointer returns to A.
- Empty queue: next_req=B with waiting=0 → B_serviceNumber=0, no call; ticket 7 issued later → call to B with number 7 starting the cycle after enqueue edge.
- Full/drop: 9 tickets (1–9) with no requests → waiting=8, queue_full=1, drop pulses on ticket 9; next_req=D then ticket 10 on grant edge → 10 accepted, waiting stays 8, drop=0.
- Wrap-around: cycle 20 tickets through DEPTH=8 FIFO with interleaved requests → numbers dispatched strictly in issue order 1…20.
